// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_t;

  // Widest operand the helper below supports.
  localparam int unsigned MaxWidth = 64;

  // Two's-complement negate when neg is set; callers size-cast the result down to their width.
  function automatic logic [MaxWidth-1:0] cond_neg(input logic [MaxWidth-1:0] v,
                                                  input logic                neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;

  // rem_in < divisor keeps partial < 2*divisor, so bit WIDTH of trial is a clean sign bit.
  always_comb begin
    partial = {rem_in, bit_in};
    trial   = partial - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider: one quotient bit per clock, sign fix-up and div-by-zero
// handling in a final cycle, results held until the next accepted start.
module div_sequencer
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  div_state_t       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] orig_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             zero_q;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  // Most-negative input maps onto itself, which is the correct magnitude read as unsigned.
  always_comb begin
    neg_a = is_signed & dividend[WIDTH-1];
    neg_b = is_signed & divisor[WIDTH-1];
    abs_a = WIDTH'(cond_neg(MaxWidth'(dividend), neg_a));
    abs_b = WIDTH'(cond_neg(MaxWidth'(divisor), neg_b));
    fix_q = WIDTH'(cond_neg(MaxWidth'(dvd_q), qneg_q));
    fix_r = WIDTH'(cond_neg(MaxWidth'(rem_q), rneg_q));
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_q),
    .bit_in (dvd_q[WIDTH-1]),
    .divisor(dsr_q),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      orig_q    <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      zero_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q  <= abs_a;
            dsr_q  <= abs_b;
            orig_q <= dividend;
            rem_q  <= '0;
            cnt_q  <= CntW'(WIDTH);
            qneg_q <= neg_a ^ neg_b;
            rneg_q <= neg_a;
            busy   <= 1'b1;
            if (divisor == '0) begin
              zero_q  <= 1'b1;
              state_q <= FIX;
            end else begin
              zero_q  <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          // Quotient bits shift into the dividend register as dividend bits shift out.
          rem_q <= step_rem;
          dvd_q <= {dvd_q[WIDTH-2:0], step_q};
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
          if (zero_q) begin
            quotient  <= '1;
            remainder <= orig_q;
            div0      <= 1'b1;
          end else begin
            quotient  <= fix_q;
            remainder <= fix_r;
            div0      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle integer divider controller for the CPU ALU. It accepts one dividend/divisor pair per start handshake and runs a restoring-division datapath one quotient bit per clock. It applies sign correction for signed operations and returns the quotient, the remainder and a divide-by-zero flag with a one-cycle done pulse. It replaces the combinational divider on the ALU path so the long carry chain is removed from the critical timing path.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- arst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only when busy=0
- is_signed  input  1  1 = two's-complement operation, 0 = unsigned
- dividend  input  WIDTH  numerator, sampled with start
- divisor  input  WIDTH  denominator, sampled with start
- busy  output  1  operation in progress; start ignored
- done  output  1  single-cycle pulse; results valid
- quotient  output  WIDTH  result, held until the next accepted start
- remainder  output  WIDTH  result, held until the next accepted start
- div0  output  1  divisor was zero; held like the results

## Operation
- States: IDLE, CALC, FIX.
- IDLE: when start=1, latch operands, sign flags and the mode.
  - Signed mode: store |dividend| and |divisor| as unsigned WIDTH-bit values. The most-negative value stays 100…0, read as unsigned.
  - Clear the partial remainder. Load bit counter = WIDTH.
  - divisor≠0 → CALC. divisor=0 → FIX with div0 set.
- CALC, once per cycle:
  - Shift {partial remainder, dividend reg} left by 1.
  - Trial-subtract the divisor from the partial remainder (WIDTH+1-bit subtract).
  - Non-negative trial result → keep the difference and shift in quotient bit 1. Negative → restore and shift in 0.
  - Decrement the counter. Counter reaches 0 → FIX.
- FIX, one cycle: write the outputs, pulse done, go to IDLE.
  - Signed, operand signs differ → negate the quotient.
  - Signed, dividend negative → negate the remainder. The remainder takes the dividend's sign.
  - div0 case: quotient = all ones, remainder = original dividend, div0 = 1.
  - Otherwise div0 = 0.
- Overflow (signed most-negative / −1): quotient = most-negative, remainder = 0, no flag. This falls out of the algorithm.
- start while busy=1: ignored, no queueing.
- Results, div0 and the latched operands change only on an accepted start or in FIX.

## Timing
- Reset: state IDLE; busy, done, div0, quotient and remainder all 0; counter 0.
- start accepted at edge k:
  - busy=1 from k+1 through the FIX edge.
  - Outputs update and done=1 for exactly one cycle after edge k+WIDTH+1. busy=0 in that same cycle.
  - Latency is WIDTH+2 edges.
- div0 path: done is high after edge k+1, a latency of 2.
- Back-to-back: start may be asserted in the done cycle. It is accepted, and done falls while busy rises at the next edge.
- arst mid-operation: immediate return to reset values. No done is produced.

## Structure
- Shared package div_pkg holds:
  - the state enum type div_state_t {IDLE, CALC, FIX}
  - the function that negates a WIDTH-bit vector on a flag.
- Sub-module div_step (combinational): one restoring-division iteration. Inputs are the partial remainder, the next dividend bit and the divisor. Outputs are the new partial remainder and the quotient bit.
- The controller instantiates div_step once and owns the counter, the registers and the FSM.

## Test plan
- WIDTH=4, unsigned, 15 / 2 → quotient=7, remainder=1, div0=0; done exactly 6 edges after the start edge.
- WIDTH=4, signed, 4'b1111 (−1) / 2 → quotient=0, remainder=4'b1111 (−1). Also −7 / 2 → quotient=4'b1101 (−3), remainder=4'b1111 (−1).
- WIDTH=8, signed, −128 / −1 → quotient=8'h80, remainder=0, div0=0.
- WIDTH=8, unsigned, 200 / 0 → div0=1, quotient=8'hFF, remainder=200, done 2 edges after start.
- Start asserted every cycle during a busy operation → only the first is accepted, one done pulse. A start in the done cycle launches the next operation immediately.
- arst asserted at CALC cycle 3 → busy, done and the outputs read 0 at once. A following 100 / 7 (WIDTH=8) → quotient=14, remainder=2.
